// File: rtl/pipe_stage_hs_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs_if
// Handshake bundle for one pipe_stage_hs instance: the upstream channel
// (in_*) and the downstream channel (out_*).
//   slave  : the pipeline stage itself (takes in_valid/in_data/out_ready,
//            drives in_ready/out_valid/out_data)
//   master : the surrounding logic (producer + consumer of the stage)
// Parameter W is the payload width and must match the stage's W.
// ---------------------------------------------------------------------------
interface pipe_stage_hs_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs
// Generic valid/ready pipeline stage register carrying an opaque payload
// between CPU pipeline stages, with synchronous flush and a saturating
// stall-cycle counter.
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry. In
// that build in_ready depends only on registered state, cpu_en and flush,
// breaking the combinational ready path from downstream. Without it the
// stage holds one entry and in_ready follows out_ready while full.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   cpu_en_i    global pipeline enable; 0 freezes the stage
//   flush_i     synchronous squash of the stage contents
//   hs          handshake bundle (slave side): in_valid/in_ready/in_data,
//               out_valid/out_ready/out_data
//   stall_cnt_o saturating count of back-pressured cycles
// ---------------------------------------------------------------------------
module pipe_stage_hs #(
    parameter int W     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en_i,
    input  logic             flush_i,
    pipe_stage_hs_if.slave   hs,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // M empty
        FULL  = 2'd1,   // M live, S empty
        SKID  = 2'd2    // M and S live (skid build only)
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic [W-1:0]     m_q;
    logic [CNT_W-1:0] cnt_q;
`ifdef PIPE_STAGE_SKID_EN
    logic [W-1:0]     s_q;
`endif

    logic acc;
    logic emit;

    // Handshake outputs are gated by cpu_en so a frozen pipeline neither
    // accepts nor emits. rst is folded into in_ready so the upstream sees
    // "not ready" for as long as reset is asserted.
`ifdef PIPE_STAGE_SKID_EN
    assign hs.in_ready = cpu_en_i & ~flush_i & ~rst & (state_q != SKID);
`else
    assign hs.in_ready = cpu_en_i & ~flush_i & ~rst &
                         ((state_q == EMPTY) | hs.out_ready);
`endif
    assign hs.out_valid = cpu_en_i & (state_q != EMPTY);
    assign hs.out_data  = m_q;
    assign stall_cnt_o  = cnt_q;

    assign acc  = hs.in_valid & hs.in_ready;
    assign emit = hs.out_valid & hs.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            m_q     <= '0;
`ifdef PIPE_STAGE_SKID_EN
            s_q     <= '0;
`endif
        end else if (flush_i) begin
            // Squash wins over everything, including a frozen pipeline.
            state_q <= EMPTY;
            m_q     <= '0;
`ifdef PIPE_STAGE_SKID_EN
            s_q     <= '0;
`endif
        end else if (cpu_en_i) begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_q <= FULL;
                        m_q     <= hs.in_data;
                    end
                end
                FULL: begin
                    if (emit && acc) begin
                        // Replace in place: no bubble at full throughput.
                        m_q <= hs.in_data;
                    end else if (emit) begin
                        state_q <= EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (acc) begin
                        // Downstream stalled but we had already advertised
                        // ready: park the beat in the skid entry.
                        state_q <= SKID;
                        s_q     <= hs.in_data;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                SKID: begin
                    if (emit) begin
                        state_q <= FULL;
                        m_q     <= s_q;
                    end
                end
`endif
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Counts cycles where a live payload is refused downstream. Flush cycles
    // are not counted, and only reset clears the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cpu_en_i && (state_q != EMPTY) && !hs.out_ready &&
                     !flush_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_hs
// Self-checking bench for pipe_stage_hs (W=64, CNT_W=4). A queue-based
// reference model tracks the stage contents as an ordered FIFO of capacity
// 1 or 2 (depending on PIPE_STAGE_SKID_EN) and predicts the handshake
// outputs and stall counter each cycle.
// ---------------------------------------------------------------------------
module tb_pipe_stage_hs;

    localparam int W       = 64;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP = SKID ? 2 : 1;

    logic             clk;
    logic             rst;
    logic             cpu_en;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stage_hs_if #(.W(W)) hs ();

    pipe_stage_hs #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_en_i   (cpu_en),
        .flush_i    (flush),
        .hs         (hs),
        .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] m_shadow;
    int           cnt_m;
    logic [W-1:0] emitted[$];
    logic         last_ir;
    logic         last_ov;

    typedef struct {
        bit           iv;
        logic [W-1:0] d;
        bit           ordy;
        bit           e_ov;
        logic [W-1:0] e_od;
        bit           e_ir;
        int           e_cnt;
    } vec_t;
    vec_t tbl[9];

    function automatic void chk(input string n, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    // Assert reset mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        cpu_en = 1'b1; flush = 1'b0;
        hs.in_valid = 1'b0; hs.in_data = '0; hs.out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_in_ready",  hs.in_ready, 0);
        chk("rst_out_valid", hs.out_valid, 0);
        chk("rst_out_data",  hs.out_data, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        mq.delete(); m_shadow = '0; cnt_m = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock cycle: drive, compare against model, advance model and DUT.
    task automatic cyc(input bit en, input bit fl, input bit iv,
                       input logic [W-1:0] d, input bit ordy);
        bit           exp_ir, exp_ov;
        logic [W-1:0] exp_od;
        cpu_en = en; flush = fl;
        hs.in_valid = iv; hs.in_data = d; hs.out_ready = ordy;
        #1;
        exp_ov = en && (mq.size() > 0);
        exp_od = m_shadow;
        exp_ir = en && !fl && ((mq.size() < CAP) || (!SKID && ordy));
        chk("out_valid", hs.out_valid, exp_ov);
        chk("out_data",  hs.out_data, exp_od);
        chk("in_ready",  hs.in_ready, exp_ir);
        chk("stall_cnt", stall_cnt, cnt_m);
        last_ir = hs.in_ready;
        last_ov = hs.out_valid;
        if (hs.out_valid && ordy) emitted.push_back(hs.out_data);
        if (fl) begin
            mq.delete();
            m_shadow = '0;
        end else if (en) begin
            if (mq.size() > 0 && !ordy && cnt_m < CNT_MAX) cnt_m++;
            if (mq.size() > 0 && ordy) void'(mq.pop_front());
            if (iv && exp_ir) mq.push_back(d);
            if (mq.size() > 0) m_shadow = mq[0];
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] src[$];
        bit pat[8];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Streaming vectors: 1..8 back to back, each emitted one cycle later.
        for (int k = 0; k < 9; k++) begin
            tbl[k].iv    = (k < 8);
            tbl[k].d     = (k < 8) ? W'(k + 1) : '0;
            tbl[k].ordy  = 1'b1;
            tbl[k].e_ov  = (k > 0);
            tbl[k].e_od  = W'(k);
            tbl[k].e_ir  = 1'b1;
            tbl[k].e_cnt = 0;
        end

        do_reset();
        for (int k = 0; k < 9; k++) begin
            cpu_en = 1'b1; flush = 1'b0;
            hs.in_valid = tbl[k].iv; hs.in_data = tbl[k].d;
            hs.out_ready = tbl[k].ordy;
            #1;
            chk("stream_out_valid", hs.out_valid, tbl[k].e_ov);
            chk("stream_out_data",  hs.out_data, tbl[k].e_od);
            chk("stream_in_ready",  hs.in_ready, tbl[k].e_ir);
            chk("stream_stall_cnt", stall_cnt, tbl[k].e_cnt);
            @(posedge clk); #1;
        end

        // Back-pressure: source keeps offering until accepted; order kept.
        do_reset();
        src = '{64'hA, 64'hB, 64'hC};
        emitted.delete();
        for (int i = 0; i < 8; i++) begin
            bit           iv;
            logic [W-1:0] d;
            iv = (src.size() > 0);
            d  = iv ? src[0] : '0;
            cyc(1'b1, 1'b0, iv, d, pat[i]);
            if (iv && last_ir) void'(src.pop_front());
        end
        chk("bp_count", emitted.size(), 3);
        chk("bp_first",  emitted[0], 64'hA);
        chk("bp_second", emitted[1], 64'hB);
        chk("bp_third",  emitted[2], 64'hC);
        chk("bp_stall_cnt", stall_cnt, 2);

        // Flush with a beat offered: nothing survives, counter kept.
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 64'hA, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 64'hB, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 64'hD, 1'b0);
        chk("flush_out_valid", hs.out_valid, 0);
        chk("flush_out_data",  hs.out_data, 0);
        emitted.delete();
        repeat (3) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("flush_no_emit", emitted.size(), 0);
        chk("flush_stall_cnt", stall_cnt, 1);

        // Freeze: payload retained, handshakes gated, counter held.
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 64'h5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 64'h9, 1'b0);
            chk("frz_in_ready",  last_ir, 0);
            chk("frz_out_valid", last_ov, 0);
        end
        emitted.delete();
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("frz_emit_count", emitted.size(), 1);
        chk("frz_emit_data",  emitted[0], 64'h5);
        chk("frz_stall_cnt",  stall_cnt, 0);

        // Saturation, then async reset with a live payload.
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 64'h77, 1'b1);
        repeat (20) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("sat_stall_cnt", stall_cnt, 15);
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (i % 64 == 63) do_reset();
            cyc(($urandom % 8) != 0, ($urandom % 16) == 0,
                ($urandom % 4) != 0, {$urandom, $urandom},
                ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised, valid/ready-handshaked pipeline stage register carrying an opaque payload between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It is the generic successor to the fixed per-stage registers. It adds:
- back-pressure, with an optional two-entry skid buffer that breaks the combinational ready path;
- a synchronous flush for branch and exception squash;
- a saturating stall-cycle counter for performance analysis.

## Interface
Parameters:
- W, default 64: payload width in bits (concatenated pc, pc+4, instruction, rd, ALU result, control fields, ...).
- CNT_W, default 16: stall counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cpu_en  input  1  global pipeline enable; 0 freezes all state except the stall counter hold.
- flush  input  1  synchronous squash of stage contents.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  W  upstream payload.
- out_valid  output  1  out_data holds a live payload.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  W  payload presented downstream.
- stall_cnt  output  CNT_W  count of back-pressured cycles.

## Operation
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Storage:
  - main register M, payload and valid;
  - skid register S, payload and valid, present only with PIPE_STAGE_SKID_EN.
- States: EMPTY (M empty), FULL (M full, S empty), SKID (M and S full).
- out_valid = cpu_en & (state != EMPTY). out_data = M payload.
- in_ready = cpu_en & ~flush & ~rst & (state != SKID) with skid. Without skid, the last term is (state == EMPTY | out_ready).
- Transitions, applied when cpu_en=1 and flush=0:
  - EMPTY: in_valid → FULL, M←in_data. Otherwise stay.
  - FULL, out_ready & in_valid → FULL, M←in_data.
  - FULL, out_ready & ~in_valid → EMPTY.
  - FULL, ~out_ready & in_valid → SKID, S←in_data. Skid build only.
  - FULL, ~out_ready & ~in_valid → stay.
  - SKID, out_ready → FULL, M←S. Otherwise stay.
- cpu_en=0 and flush=0: no state or payload change. No accept or emit occurs, because both handshake outputs are gated.
- flush=1, regardless of cpu_en:
  - next state is EMPTY;
  - M and S payloads are cleared to 0;
  - any input offered that cycle is dropped and in_ready=0.
- Flush takes priority over all other transitions. It does not clear stall_cnt.
- stall_cnt:
  - increments when cpu_en & (state != EMPTY) & ~out_ready & ~flush;
  - saturates at 2^CNT_W−1 with no wrap;
  - is cleared only by rst.
- Payload is opaque. No field is interpreted and no width conversion is performed.

## Timing
- Reset values:
  - state EMPTY and out_valid 0;
  - out_data 0 and S payload 0;
  - stall_cnt 0;
  - in_ready 0 while rst is high, then cpu_en once released.
- Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N. This is 1 cycle.
- Throughput: 1 payload per cycle with out_ready held high.
- Skid build: in_ready is a function of registered state plus cpu_en and flush only. It has no out_ready dependence.
- Skid build drain: after a stall in SKID, the first out_ready cycle emits M, then S follows on the next cycle. No payload is lost or duplicated, and order is preserved.
- Reset mid-operation clears both entries immediately (asynchronous). Outputs return to reset values without waiting for a clock edge.
- A simultaneous accept and emit in FULL replaces M in place. No bubble is inserted.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - S register and SKID state are present;
  - in_ready is registered-path only;
  - 2-entry effective capacity.
- PIPE_STAGE_SKID_EN undefined:
  - single-entry stage, states EMPTY/FULL only;
  - in_ready combinationally depends on out_ready;
  - S logic is absent.
- Ports, reset values, flush and counter behaviour are identical in both builds.

## Test plan
- Streaming: W=64, cpu_en=1, out_ready=1, inputs 0x1..0x8 on consecutive cycles → out_data 0x1..0x8 on the next 8 cycles, each one cycle after accept. out_valid stays high, stall_cnt=0.
- Back-pressure (skid build): with 0xA in M, hold out_ready=0 and offer 0xB, then 0xC → 0xB is accepted into S and 0xC is held off with in_ready=0. Release out_ready → 0xA, 0xB, 0xC are emitted in order. stall_cnt equals the held cycles.
- Flush: state SKID holding 0xA/0xB, pulse flush with in_valid=1 and data 0xD → next cycle out_valid=0, out_data=0, and 0xD is never emitted.
- Freeze: in FULL with 0x5, cpu_en=0 for 3 cycles with in_valid=1 → in_ready=0 and out_valid=0. Payload 0x5 is retained and emitted once cpu_en=1. stall_cnt does not increment.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with a live payload → stall_cnt stops at 15. Async rst mid-cycle → stall_cnt=0 and out_valid=0 before the next edge.
